apb_slave_mem: RTL



---
 rtl/ahb_apb_bridge_pkg.sv | 20 ++
 rtl/apb_slave_ram.sv | 33 +++
 rtl/apb_slave_mem.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge and its APB completer models.
// Holds the completer FSM encoding and the PPROT bit positions used by the bridge.
package ahb_apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } apb_slv_fsm_states;

    // PPROT[0] set marks a privileged access
    localparam logic [1:0] PPROT_PRIVILEGED = 2'd0;

    localparam int unsigned WAIT_CNT_W = 4;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_ram.sv
// DEPTH x PDATA_SIZE word store with per-byte write enables.
// One synchronous write port, one asynchronous read port, no reset.
module apb_slave_ram
    import ahb_apb_bridge_pkg::*;
#(
    parameter int unsigned PDATA_SIZE = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned AW         = clog2_min1(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [PDATA_SIZE/8-1:0] be_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic [PDATA_SIZE-1:0]   wdata_i,
    input  logic [AW-1:0]           raddr_i,
    output logic [PDATA_SIZE-1:0]   rdata_o
);

    localparam int unsigned NB = PDATA_SIZE / 8;

    logic [PDATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: byte-strobed word memory, read-only ID word at index 0,
// privilege-protected upper region and a fixed number of wait states.
module apb_slave_mem
    import ahb_apb_bridge_pkg::*;
#(
    parameter int unsigned            PADDR_SIZE  = 10,
    parameter int unsigned            PDATA_SIZE  = 8,
    parameter int unsigned            DEPTH       = 64,
    parameter int unsigned            WAIT_CYCLES = 0,
    parameter int unsigned            PROT_BASE   = 32,
    parameter logic [PDATA_SIZE-1:0]  ID_VALUE    = 'hA5
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [2:0]              PPROT,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int unsigned NB       = PDATA_SIZE / 8;
    localparam int unsigned ADDR_LSB = $clog2(NB);
    localparam int unsigned AW       = clog2_min1(DEPTH);
    localparam int unsigned IW       = (PADDR_SIZE > 32) ? PADDR_SIZE : 32;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    apb_slv_fsm_states     state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [AW-1:0]         idx_q;
    logic                  write_q;
    logic                  err_q;
    logic                  ready_q;
    logic                  slverr_q;
    logic [PDATA_SIZE-1:0] rdata_q;

    logic [IW-1:0]         setup_idx;
    logic                  err_d;
    logic [AW-1:0]         rd_idx_d;
    logic                  rd_err_d;
    logic                  rd_wr_d;
    logic [PDATA_SIZE-1:0] rdata_d;
    logic [PDATA_SIZE-1:0] ram_rdata;
    logic                  we_d;
    logic                  prot_unused;

    assign prot_unused = ^PPROT[2:1];

    // Index kept at full address width so out-of-range accesses are not aliased
    assign setup_idx = IW'(PADDR) >> ADDR_LSB;

    always_comb begin
        err_d = 1'b0;
        if (setup_idx >= IW'(DEPTH)) begin
            err_d = 1'b1;
        end
        if (PWRITE && (setup_idx == '0)) begin
            err_d = 1'b1;
        end
        if ((setup_idx >= IW'(PROT_BASE)) && !PPROT[PPROT_PRIVILEGED]) begin
            err_d = 1'b1;
        end
    end

    // With zero wait states the response is captured in the setup cycle itself,
    // so the read port follows the live address while idle.
    always_comb begin
        rd_idx_d = idx_q;
        rd_err_d = err_q;
        rd_wr_d  = write_q;
        if (state_q == ST_IDLE) begin
            rd_idx_d = setup_idx[AW-1:0];
            rd_err_d = err_d;
            rd_wr_d  = PWRITE;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (!rd_wr_d && !rd_err_d) begin
            rdata_d = (rd_idx_d == '0) ? ID_VALUE : ram_rdata;
        end
    end

    assign we_d = !PRESET && (state_q == ST_READY) && PSEL && PENABLE
                  && write_q && !err_q;

    apb_slave_ram #(
        .PDATA_SIZE (PDATA_SIZE),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk_i   (PCLK),
        .we_i    (we_d),
        .be_i    (PSTRB),
        .waddr_i (idx_q),
        .wdata_i (PWDATA),
        .raddr_i (rd_idx_d),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        idx_q   <= setup_idx[AW-1:0];
                        write_q <= PWRITE;
                        err_q   <= err_d;
                        cnt_q   <= WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            state_q  <= ST_READY;
                            ready_q  <= 1'b1;
                            slverr_q <= err_d;
                            rdata_q  <= rdata_d;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state_q <= ST_IDLE;
                    end else if (PENABLE) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                        if (cnt_q <= 4'd1) begin
                            state_q  <= ST_READY;
                            ready_q  <= 1'b1;
                            slverr_q <= err_q;
                            rdata_q  <= rdata_d;
                        end
                    end
                end
                ST_READY: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;
    assign PRDATA  = rdata_q;

endmodule
